// File: rtl/wb_byte_in_pkg.sv
// Shared constants and types for the wb_byte_in byte-wide input client.
package wb_byte_in_pkg;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 2;

   localparam logic [AW-1:0] ADR_PIN  = 2'd0;
   localparam logic [AW-1:0] ADR_CHG  = 2'd1;
   localparam logic [AW-1:0] ADR_MASK = 2'd2;
   localparam logic [AW-1:0] ADR_RSVD = 2'd3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;
   localparam logic [1:0] ACK  = 2'd3;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/wb_byte_in_if.sv
// Byte-wide peripheral bus between the CPU-side master and the wb_byte_in client.
interface wb_byte_in_if;
   import wb_byte_in_pkg::*;

   logic          STB_I;
   logic          WE_I;
   logic [AW-1:0] ADR_I;
   logic [DW-1:0] DAT_I;
   logic [DW-1:0] DAT_O;
   logic          ACK_O;

   modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
   modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);

endinterface

// File: rtl/wb_byte_in_filter.sv
// Input conditioning: two-flop synchronizer, plus a two-tick debounce when
// WB_BYTE_IN_DEBOUNCE_EN is defined. f_next_c lets the parent flag changes on the edge F moves.
module byte_in_filter
   import wb_byte_in_pkg::*;
#(
   parameter int unsigned DEB_DIV = 50000
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] P,
   output logic [DW-1:0] F,
   output logic [DW-1:0] f_next_c
);

   logic [DW-1:0] s1;
   logic [DW-1:0] s2;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         s1 <= '0;
         s2 <= '0;
         F  <= '0;
      end else begin
         s1 <= P;
         s2 <= s1;
         F  <= f_next_c;
      end
   end

`ifdef WB_BYTE_IN_DEBOUNCE_EN
   localparam int unsigned CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [DW-1:0] prev;
   logic [DW-1:0] agree_c;
   logic          tick_c;

   assign tick_c  = (cnt == CW'(DEB_DIV - 1));
   assign agree_c = ~(s2 ^ prev);

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         cnt  <= '0;
         prev <= '0;
      end else begin
         cnt <= tick_c ? '0 : cnt + CW'(1);
         if (tick_c) prev <= s2;
      end
   end

   // A bit only moves when it read the same level on this tick and the previous one.
   assign f_next_c = tick_c ? ((F & ~agree_c) | (s2 & agree_c)) : F;
`else
   logic unused_deb_c;

   assign unused_deb_c = ^DEB_DIV;
   assign f_next_c     = s2;
`endif

endmodule

// File: rtl/wb_byte_in.sv
// Bus client exposing a filtered 8-bit input port with sticky change flags and a
// masked level interrupt. Optional debounce via WB_BYTE_IN_DEBOUNCE_EN.
module wb_byte_in
   import wb_byte_in_pkg::*;
#(
   parameter int unsigned DEB_DIV = 50000
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   wb_byte_in_if.slave   bus,
   input  logic [DW-1:0] P,
   output logic          IRQ_O
);

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [DW-1:0] f;
   logic [DW-1:0] f_next_c;
   logic [DW-1:0] chg;
   logic [DW-1:0] chg_next;
   logic [DW-1:0] chg_clr;
   logic [DW-1:0] mask;
   logic [DW-1:0] mask_next;
   logic [DW-1:0] dat;
   logic [DW-1:0] dat_next;
   logic          ack;
   logic          ack_next;
   logic          irq_next;
   wb_req_t       req_c;

   byte_in_filter #(.DEB_DIV(DEB_DIV)) u_filter (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .P        (P),
      .F        (f),
      .f_next_c (f_next_c)
   );

   assign req_c     = '{we: bus.WE_I, adr: bus.ADR_I, dat: bus.DAT_I};
   assign bus.DAT_O = dat;
   assign bus.ACK_O = ack;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state <= IDLE;
         chg   <= '0;
         mask  <= '0;
         dat   <= '0;
         ack   <= 1'b0;
         IRQ_O <= 1'b0;
      end else begin
         state <= state_next;
         chg   <= chg_next;
         mask  <= mask_next;
         dat   <= dat_next;
         ack   <= ack_next;
         IRQ_O <= irq_next;
      end
   end

   always_comb begin
      state_next = state;
      chg_clr    = '0;
      mask_next  = mask;
      dat_next   = dat;
      ack_next   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.STB_I) state_next = req_c.we ? WR : RD;
         end
         WR: begin
            state_next = ACK;
            ack_next   = 1'b1;
            if (req_c.adr == ADR_CHG)  chg_clr   = req_c.dat;
            if (req_c.adr == ADR_MASK) mask_next = req_c.dat;
         end
         RD: begin
            state_next = ACK;
            ack_next   = 1'b1;
            case (req_c.adr)
               ADR_PIN:  dat_next = f;
               ADR_CHG:  dat_next = chg;
               ADR_MASK: dat_next = mask;
               default:  dat_next = '0;
            endcase
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // A change landing on the same edge as a clear survives the clear.
      chg_next = (chg & ~chg_clr) | (f_next_c ^ f);
      irq_next = |(chg_next & mask_next);
   end

endmodule
